// File: rtl/mem_pkg.sv
// Shared memory-access definitions: responder state encoding, funct3 size codes
// and the captured request payload.
package mem_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic            we;
        logic [2:0]      funct3;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/byte_lane_decoder.sv
// Combinational decode of access size and byte offset into lane enables plus
// misalignment / illegal-encoding flags.
module byte_lane_decoder
    import mem_pkg::*;
(
    input  logic [2:0]       funct3,
    input  logic [1:0]       addr_lo,
    input  logic             we,
    output logic [LANES-1:0] lane_en_c,
    output logic             misalign_c,
    output logic             illegal_c
);

    always_comb begin
        lane_en_c  = '0;
        misalign_c = 1'b0;
        illegal_c  = 1'b0;
        unique case (funct3)
            F3_SB:  lane_en_c = 4'b0001 << addr_lo;
            F3_SH: begin
                lane_en_c  = addr_lo[1] ? 4'b1100 : 4'b0011;
                misalign_c = addr_lo[0];
            end
            F3_SW: begin
                lane_en_c  = 4'b1111;
                misalign_c = (addr_lo != 2'b00);
            end
            // Unsigned loads have no store counterpart.
            F3_LBU: illegal_c = we;
            F3_LHU: begin
                illegal_c  = we;
                misalign_c = addr_lo[0];
            end
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_ram_responder.sv
// Single-outstanding data RAM responder: accepts one request in IDLE, waits a
// fixed latency, then pulses a one-cycle response with the aligned word.
module data_ram_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] addr,
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rdata,
    output logic            err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    mem_req_t        req_q, req_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    mem_req_t        cur_c;
    logic [LANES-1:0] lane_en_c;
    logic            misalign_c, illegal_c, range_err_c, acc_err_c;
    logic            enter_resp_c, wr_en_c;
    logic [AW-1:0]   word_idx_c;
    logic [XLEN-1:0] wr_data_c;

    // With zero latency the response is formed on the accept edge, so use the live inputs.
    assign cur_c = (state_q == ST_IDLE) ? mem_req_t'{addr, we, funct3, wdata} : req_q;

    byte_lane_decoder u_dec (
        .funct3     (cur_c.funct3),
        .addr_lo    (cur_c.addr[1:0]),
        .we         (cur_c.we),
        .lane_en_c  (lane_en_c),
        .misalign_c (misalign_c),
        .illegal_c  (illegal_c)
    );

    assign word_idx_c   = cur_c.addr[AW+1:2];
    assign range_err_c  = ({2'b00, cur_c.addr[XLEN-1:2]} >= XLEN'(DEPTH_WORDS));
    assign acc_err_c    = misalign_c | illegal_c | range_err_c;
    assign enter_resp_c = (state_d == ST_RESP) && (state_q != ST_RESP);
    assign wr_en_c      = enter_resp_c & cur_c.we & ~acc_err_c & ~reset;

    always_comb begin
        wr_data_c = cur_c.wdata;
        if (cur_c.funct3 == F3_SB) wr_data_c = {4{cur_c.wdata[7:0]}};
        if (cur_c.funct3 == F3_SH) wr_data_c = {2{cur_c.wdata[15:0]}};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d = mem_req_t'{addr, we, funct3, wdata};
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CW'(LATENCY);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Response fields are latched on the edge entering RESP; stores return a zero word.
    always_comb begin
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        err_d       = enter_resp_c & acc_err_c;
        rdata_d     = '0;
        if (enter_resp_c && !acc_err_c && !cur_c.we) rdata_d = mem_q[word_idx_c];
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (wr_en_c) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_en_c[i]) mem_q[word_idx_c][8*i +: 8] <= wr_data_c[8*i +: 8];
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rdata     = rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Randomized self-checking bench for data_ram_responder against a byte-level memory model.
module tb_data_ram_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
    localparam int unsigned NW    = 16;

    logic        clock = 1'b0;
    logic        reset, req_valid, we;
    logic [31:0] addr, wdata;
    logic [2:0]  funct3;
    logic        req_ready, rsp_valid, err;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_m [NW];

    data_ram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .addr      (addr),
        .we        (we),
        .funct3    (funct3),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rdata     (rdata),
        .err       (err)
    );

    always #5 clock = ~clock;

    function automatic logic exp_err(input logic [31:0] a, input logic w, input logic [2:0] f);
        if ((a >> 2) >= DEPTH) return 1'b1;
        case (f)
            3'd0:    return 1'b0;
            3'd1:    return a[0];
            3'd2:    return (a % 4) != 0;
            3'd4:    return w;
            3'd5:    return w | a[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] wd);
        logic [3:0] wi;
        int         sh;
        wi = a[5:2];
        sh = 8 * int'(a % 4);
        case (f)
            3'd0: mem_m[wi] = (mem_m[wi] & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            3'd1: begin
                sh = 8 * int'(a % 4) / 16 * 16;
                mem_m[wi] = (mem_m[wi] & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
            end
            default: mem_m[wi] = wd;
        endcase
    endfunction

    // Issues one request from idle and waits (bounded) for its response pulse.
    task automatic do_req(input logic [31:0] a, input logic w, input logic [2:0] f, input logic [31:0] wd,
                          output logic rdy0, output int lat, output logic [31:0] rd, output logic er,
                          output logic tail_ok);
        @(negedge clock);
        rdy0 = req_ready;
        addr = a; we = w; funct3 = f; wdata = wd; req_valid = 1'b1;
        @(posedge clock);
        lat = 0; rd = 32'hX; er = 1'bx;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            req_valid = 1'b0;
            if (rsp_valid === 1'b1) begin
                lat = n; rd = rdata; er = err;
                break;
            end
        end
        @(negedge clock);
        tail_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1) && (rdata === 32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; addr = '0; we = 1'b0; funct3 = '0; wdata = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    endtask

    task automatic test_preload();
        logic rdy0, er, tail_ok; int lat; logic [31:0] rd, v;
        for (int i = 0; i < int'(NW); i++) begin
            v = $urandom;
            do_req(32'(i * 4), 1'b1, 3'd2, v, rdy0, lat, rd, er, tail_ok);
            model_store(32'(i * 4), 3'd2, v);
            n_checks++; if (er !== 1'b0 || lat != int'(LAT) + 1) begin
                n_fail++; $display("FAIL preload word %0d: err %b lat %0d expected err 0 lat %0d", i, er, lat, LAT + 1);
            end
        end
    endtask

    task automatic test_directed();
        logic rdy0, er, tail_ok; int lat; logic [31:0] rd;
        do_req(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, rdy0, lat, rd, er, tail_ok);
        model_store(32'h10, 3'd2, 32'hDEADBEEF);
        do_req(32'h10, 1'b0, 3'd2, 32'h0, rdy0, lat, rd, er, tail_ok);
        n_checks++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL lw_ready: got %b expected 1", rdy0); end
        n_checks++; if (lat != int'(LAT) + 1) begin n_fail++; $display("FAIL lw_latency: got %0d expected %0d", lat, LAT + 1); end
        n_checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++; $display("FAIL sw_lw: got %h err %b expected deadbeef err 0", rd, er); end
        n_checks++; if (!tail_ok) begin n_fail++; $display("FAIL lw_pulse: got tail_ok %b expected 1", tail_ok); end

        do_req(32'h13, 1'b1, 3'd0, 32'h000000AA, rdy0, lat, rd, er, tail_ok);
        model_store(32'h13, 3'd0, 32'hAA);
        do_req(32'h10, 1'b1, 3'd1, 32'h00001234, rdy0, lat, rd, er, tail_ok);
        model_store(32'h10, 3'd1, 32'h1234);
        do_req(32'h10, 1'b0, 3'd2, 32'h0, rdy0, lat, rd, er, tail_ok);
        n_checks++; if (rd !== 32'hAAAD1234 || er !== 1'b0) begin n_fail++; $display("FAIL sb_sh_merge: got %h err %b expected aaad1234 err 0", rd, er); end

        do_req(32'h12, 1'b1, 3'd2, 32'h11223344, rdy0, lat, rd, er, tail_ok);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL sw_misalign: got err %b rdata %h expected err 1 rdata 0", er, rd); end
        do_req(32'h10, 1'b0, 3'd2, 32'h0, rdy0, lat, rd, er, tail_ok);
        n_checks++; if (rd !== 32'hAAAD1234) begin n_fail++; $display("FAIL misalign_no_write: got %h expected aaad1234", rd); end
        do_req(32'h11, 1'b0, 3'd1, 32'h0, rdy0, lat, rd, er, tail_ok);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL lh_misalign: got err %b rdata %h expected err 1 rdata 0", er, rd); end
        do_req(32'h1000, 1'b0, 3'd2, 32'h0, rdy0, lat, rd, er, tail_ok);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL out_of_range: got err %b rdata %h expected err 1 rdata 0", er, rd); end
    endtask

    task automatic test_random();
        logic rdy0, er, tail_ok, w, e; int lat; logic [31:0] rd, a, wd; logic [2:0] f;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) a = 32'((DEPTH + $urandom_range(0, 200)) * 4 + $urandom_range(0, 3));
            else                           a = 32'($urandom_range(0, NW - 1) * 4 + $urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            f  = 3'($urandom_range(0, 7));
            wd = $urandom;
            e  = exp_err(a, w, f);
            do_req(a, w, f, wd, rdy0, lat, rd, er, tail_ok);
            if (w && !e) model_store(a, f, wd);
            n_checks++; if (rdy0 !== 1'b1 || lat != int'(LAT) + 1 || !tail_ok) begin
                n_fail++; $display("FAIL rand_handshake #%0d: ready %b lat %0d tail %b expected 1 %0d 1", i, rdy0, lat, tail_ok, LAT + 1);
            end
            n_checks++; if (er !== e) begin n_fail++; $display("FAIL rand_err #%0d a=%h we=%b f3=%0d: got %b expected %b", i, a, w, f, er, e); end
            if (!w || e) begin
                n_checks++;
                if (rd !== ((e || w) ? 32'h0 : mem_m[a[5:2]])) begin
                    n_fail++; $display("FAIL rand_rdata #%0d a=%h f3=%0d: got %h expected %h", i, a, f, rd, e ? 32'h0 : mem_m[a[5:2]]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_rdy, exp_rsp;
        @(negedge clock);
        addr = 32'h10; we = 1'b0; funct3 = 3'd2; wdata = '0; req_valid = 1'b1;
        for (int c = 0; c < 3 * int'(LAT + 2); c++) begin
            if (c > 0) @(negedge clock);
            exp_rdy = (c % int'(LAT + 2)) == 0;
            exp_rsp = (c % int'(LAT + 2)) == int'(LAT) + 1;
            n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_ready c=%0d: got %b expected %b", c, req_ready, exp_rdy); end
            n_checks++; if (rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL b2b_rsp c=%0d: got %b expected %b", c, rsp_valid, exp_rsp); end
            if (exp_rsp) begin
                n_checks++; if (rdata !== mem_m[4]) begin n_fail++; $display("FAIL b2b_rdata c=%0d: got %h expected %h", c, rdata, mem_m[4]); end
            end
        end
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic rdy0, er, tail_ok, seen; int lat; logic [31:0] rd;
        @(negedge clock);
        addr = 32'h20; we = 1'b1; funct3 = 3'd2; wdata = 32'h55; req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0; reset = 1'b1;
        seen = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_idle: got ready %b expected 1", req_ready); end
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid !== 1'b0) seen = 1'b1;
            @(negedge clock);
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_rsp: got seen %b expected 0", seen); end
        do_req(32'h20, 1'b0, 3'd2, 32'h0, rdy0, lat, rd, er, tail_ok);
        n_checks++; if (rd !== mem_m[8] || er !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_write: got %h err %b expected %h err 0", rd, er, mem_m[8]); end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_ram_responder.md
DATA_RAM_RESPONDER -- requirements
Module: data_ram_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words (power of two, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the wait cycles between request acceptance and response (0..15).
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, the CPU presents a memory request.
REQ-006 SHALL have port req_ready, output, 1, the responder accepts a request this cycle.
REQ-007 SHALL have port addr, input, 32, the byte address (the CPU ALU result).
REQ-008 SHALL have port we, input, 1: 1 = store, 0 = load.
REQ-009 SHALL have port funct3, input, 3, the access size taken from instruction bits 14:12.
REQ-010 SHALL have port wdata, input, 32, store data right-aligned in the low bits.
REQ-011 SHALL have port rsp_valid, output, 1, a one-cycle response pulse.
REQ-012 SHALL have port rdata, output, 32, the full aligned word read; the CPU performs load extension itself.
REQ-013 SHALL have port err, output, 1, qualified by rsp_valid; flags a rejected access.

Function
REQ-014 SHALL implement the states IDLE, WAIT and RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid & req_ready, and addr/we/funct3/wdata are captured that edge.
REQ-016 SHALL, on accept, go to WAIT with counter=LATENCY, or go directly to RESP if LATENCY=0.
REQ-017 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the cycle after the counter reaches 1.
REQ-018 SHALL, in RESP, assert rsp_valid for exactly one cycle, then return to IDLE, with no backpressure on the response.
REQ-019 SHALL give a total latency of accept edge to rsp_valid high of LATENCY+1 cycles.
REQ-020 SHALL ignore req_valid outside IDLE; a held request is accepted again only after returning to IDLE.
REQ-021 SHALL perform a store's memory write on the edge entering RESP, and only if err=0.
REQ-022 SHALL use the word index addr[31:2] and byte lane addr[1:0].
REQ-023 SHALL apply these store lane rules:
- funct3 000 (SB): writes byte lane addr[1:0] with wdata[7:0].
- funct3 001 (SH): writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
- funct3 010 (SW): writes all lanes.
REQ-024 SHALL, for a load, return the whole word at the word index in rdata, for funct3 000, 001, 010, 100 or 101.
REQ-025 SHALL set err=1 and suppress the write for any of these:
- a reserved funct3 (011, 110, 111), or funct3 100/101 on a store;
- SH or LH/LHU with addr[0]=1;
- SW or LW with addr[1:0]!=0;
- a word index >= DEPTH_WORDS.
REQ-026 SHALL drive rdata=0 when err=1, and also whenever rsp_valid=0.
REQ-027 SHALL make a load that follows a store to the same word return the updated data, with no hazard window.

Reset
REQ-028 SHALL, on reset, force state=IDLE, counter=0, req_ready=1, rsp_valid=0, rdata=0 and err=0.
REQ-029 SHALL, when reset is asserted mid-WAIT, abort the transaction: no write occurs and no rsp_valid is produced.
REQ-030 SHALL leave memory contents unchanged by reset.

Structure
REQ-031 SHALL place the state encoding (IDLE/WAIT/RESP) and the funct3 size constants (SB/SH/SW/LBU/LHU) in a shared package mem_pkg, which the CPU-side length changers also use.
REQ-032 SHALL use one sub-module, byte_lane_decoder (funct3, addr[1:0], we → 4-bit lane enable, misalign flag, illegal flag), which is combinational.
REQ-033 SHALL implement storage as an array of DEPTH_WORDS x 32 with per-byte write enables.

Verification
REQ-034 SHALL cover an SW then LW: SW addr=0x10, wdata=0xDEADBEEF, then LW addr=0x10 → rsp_valid at accept+3 (LATENCY=2), rdata=0xDEADBEEF, err=0.
REQ-035 SHALL cover byte and halfword stores: after the above, SB addr=0x13 wdata=0x000000AA, then SH addr=0x10 wdata=0x00001234 → LW 0x10 returns 0xAAAD1234.
REQ-036 SHALL cover misalignment: SW addr=0x12 → err=1, rdata=0, and a subsequent LW 0x10 is unchanged; LH addr=0x11 → err=1.
REQ-037 SHALL cover out-of-range access with DEPTH_WORDS=1024: LW addr=0x1000 → err=1, rdata=0.
REQ-038 SHALL cover handshake behaviour: req_valid held high continuously → req_ready=0 in WAIT/RESP, one rsp_valid per accept, and accepts spaced LATENCY+2 cycles apart.
REQ-039 SHALL cover reset mid-operation: assert reset for 1 cycle during WAIT of SW 0x20 wdata=0x55 → no rsp_valid, LW 0x20 returns the prior value, state=IDLE.
